// File: rtl/sa_skew_feeder_if.sv
// Handshake and edge-stream bundle between the skew feeder and its neighbours.
// The slave modport is the feeder side, and the master modport is the producer/array side.
interface sa_skew_feeder_if #(
    parameter int N = 4,
    parameter int W = 4
);
    logic           load_valid_i;
    logic           load_ready_o;
    logic [N*W-1:0] load_data_i;
    logic           start_i;
    logic           busy_o;
    logic [N*W-1:0] edge_o;
    logic [N-1:0]   edge_valid_o;
    logic           done_o;

    modport master (
        output load_valid_i, load_data_i, start_i,
        input  load_ready_o, busy_o, edge_o, edge_valid_o, done_o
    );

    modport slave (
        input  load_valid_i, load_data_i, start_i,
        output load_ready_o, busy_o, edge_o, edge_valid_o, done_o
    );
endinterface

// File: rtl/sa_skew_feeder.sv
// Buffers an NxN operand matrix row by row, then streams it diagonally skewed onto an array edge.
// Optional macro SA_SKEW_FEEDER_REPLAY_EN adds replay_i, which re-arms the held matrix after DONE.
module sa_skew_feeder #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef SA_SKEW_FEEDER_REPLAY_EN
    input  logic             replay_i,
`endif
    sa_skew_feeder_if.slave  bus
);
    localparam int CW   = $clog2(N + 1);
    localparam int TW   = $clog2(2 * N);
    localparam int LAST = 2 * N - 2;

    typedef enum logic [1:0] {IDLE, FULL, STREAM, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [TW-1:0]  t_q, t_d;
    logic           load_fire;
    logic [N*W-1:0] row_buf_q [N];

    logic [N*W-1:0] edge_q, edge_d;
    logic [N-1:0]   valid_q, valid_d;
    logic           busy_q;
    logic           done_q;

    // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        t_d       = t_q;
        load_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_valid_i) begin
                    load_fire = 1'b1;
                    wr_cnt_d  = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == CW'(N - 1)) state_d = FULL;
                end
            end
            FULL: begin
                if (bus.start_i) begin
                    state_d = STREAM;
                    t_d     = '0;
                end
            end
            STREAM: begin
                if (t_q == TW'(LAST)) state_d = DONE;
                else                  t_d     = t_q + 1'b1;
            end
            DONE: begin
                wr_cnt_d = '0;
                state_d  = IDLE;
`ifdef SA_SKEW_FEEDER_REPLAY_EN
                if (replay_i) state_d = FULL;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // The next beat is computed from the next beat index, so the registered outputs line up with busy_o.
    always_comb begin
        int col;
        col     = 0;
        edge_d  = '0;
        valid_d = '0;
        if (state_d == STREAM) begin
            for (int r = 0; r < N; r++) begin
                col = int'(t_d) - r;
                if (col >= 0 && col < N) begin
                    edge_d[r*W +: W] = row_buf_q[r][col*W +: W];
                    valid_d[r]       = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wr_cnt_q <= '0;
            t_q      <= '0;
            edge_q   <= '0;
            valid_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            t_q      <= t_d;
            edge_q   <= edge_d;
            valid_q  <= valid_d;
            busy_q   <= (state_d == STREAM);
            done_q   <= (state_d == DONE);
        end
    end

    // NOTE: the row buffer has no reset, because rows are always written before they are read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N; i++) begin
            if (load_fire && wr_cnt_q == CW'(i)) row_buf_q[i] <= bus.load_data_i;
        end
    end

    assign bus.load_ready_o = (state_q == IDLE);
    assign bus.busy_o       = busy_q;
    assign bus.edge_o       = edge_q;
    assign bus.edge_valid_o = valid_q;
    assign bus.done_o       = done_q;
endmodule
